regfile_write_sched: RTL and testbench

Write-port scheduler for a single-write-port register file. Shares one write port among `REQS` requesters with round-robin arbitration over valid/ready handshakes, and sequences a full clear sweep of the array after reset or on command. It sits between the producers that update architectural state and the register file's `writeEn`/`writeIndex`/`writeData` inputs, driving them with `writes = 1`.

---
 rtl/regfile_sched_pkg.sv | 13 +
 rtl/regfile_write_sched_rr_arbiter.sv | 39 +++
 rtl/regfile_write_sched.sv | 121 ++++++++++++
 tb/tb_regfile_write_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
//   sched_state_t : scheduler state (sweep in progress / normal arbitration)
//   STAT_W        : width of each per-requester grant counter
package regfile_sched_pkg;

    typedef enum logic {
        SCHED_CLEAR,
        SCHED_RUN
    } sched_state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/regfile_write_sched_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at requester 'ptr'.
// The first valid requester found after that point wins.
// The rotating pointer itself lives in the parent.
//   req       in  REQS   : request vector
//   ptr       in  IDX_W  : highest-priority requester this cycle
//   en        in  1      : arbitration enable; low forces no grant
//   grant     out REQS   : one-hot grant, or zero
//   grant_idx out IDX_W  : encoded index of the winner (0 when no grant)
module rr_arbiter #(
    parameter int REQS  = 4,
    parameter int IDX_W = (REQS > 1) ? $clog2(REQS) : 1
) (
    input  logic [REQS-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [REQS-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int  j;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < REQS; k++) begin
            // Walk the requesters in rotated order: ptr, ptr+1, ... with wrap.
            j = int'(ptr) + k;
            if (j >= REQS) j = j - REQS;
            if (en && !found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Single-write-port register-file scheduler.
// Several producers share the one write port, with round-robin arbitration
// over valid/ready handshakes. After reset, or on a 'clear' pulse, the block
// writes CLEAR_VALUE to entries 0..SIZE-1, one entry per cycle.
//   clk, rst_n              : clock; asynchronous active-low reset
//   req_valid/req_ready     : per-requester handshake (ready is one-hot or zero)
//   req_index/req_data      : flattened per-requester write index/data
//   clear                   : pulse that restarts the clear sweep
//   busy                    : high while the sweep is in progress
//   wr_en/wr_index/wr_data  : registered register-file write port
//   grant_count             : per-requester saturating accept counters. This
//                             port exists only when REGFILE_SCHED_STATS_EN is
//                             defined.
module regfile_write_sched
    import regfile_sched_pkg::*;
#(
    parameter int               REQS        = 4,
    parameter int               WIDTH       = 32,
    parameter int               N           = 5,
    parameter int               SIZE        = 32,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQS-1:0]       req_valid,
    output logic [REQS-1:0]       req_ready,
    input  logic [REQS*N-1:0]     req_index,
    input  logic [REQS*WIDTH-1:0] req_data,
    input  logic                  clear,
    output logic                  busy,
    output logic                  wr_en,
    output logic [N-1:0]          wr_index,
    output logic [WIDTH-1:0]      wr_data
`ifdef REGFILE_SCHED_STATS_EN
    ,
    output logic [REQS*STAT_W-1:0] grant_count
`endif
);

    localparam int           IDX_W = (REQS > 1) ? $clog2(REQS) : 1;
    localparam logic [N-1:0] LAST  = N'(SIZE - 1);

    sched_state_t     state;
    logic [N-1:0]     cnt;
    logic [IDX_W-1:0] ptr;
    logic [REQS-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             arb_en;
    logic             accept;

    // A clear pulse in RUN blocks acceptance in that same cycle.
    assign arb_en    = (state == SCHED_RUN) && !clear;
    assign req_ready = grant;
    assign accept    = |grant;
    assign busy      = (state == SCHED_CLEAR);

    rr_arbiter #(
        .REQS  (REQS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SCHED_CLEAR;
            cnt      <= '0;
            ptr      <= '0;
            wr_en    <= 1'b0;
            wr_index <= '0;
            wr_data  <= '0;
        end else if (clear) begin
            // Restart the sweep from entry 0 on the next cycle. Nothing is
            // written in the cycle that carries the pulse.
            state <= SCHED_CLEAR;
            cnt   <= '0;
            wr_en <= 1'b0;
        end else begin
            case (state)
                SCHED_CLEAR: begin
                    wr_en    <= 1'b1;
                    wr_index <= cnt;
                    wr_data  <= CLEAR_VALUE;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) state <= SCHED_RUN;
                end
                SCHED_RUN: begin
                    wr_en <= accept;
                    if (accept) begin
                        wr_index <= req_index[int'(grant_idx)*N +: N];
                        wr_data  <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
                        ptr      <= (grant_idx == IDX_W'(REQS - 1)) ? '0
                                                                    : grant_idx + 1'b1;
                    end
                end
                default: state <= SCHED_CLEAR;
            endcase
        end
    end

`ifdef REGFILE_SCHED_STATS_EN
    logic [REQS-1:0][STAT_W-1:0] stat_q;

    // Only rst_n clears these counters. A clear pulse leaves them unchanged.
    for (genvar i = 0; i < REQS; i++) begin : g_stat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                stat_q[i] <= '0;
            else if (grant[i] && stat_q[i] != '1)
                stat_q[i] <= stat_q[i] + 1'b1;
        end
    end

    assign grant_count = stat_q;
`endif

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed self-checking bench for regfile_write_sched with default parameters
// (REQS=4, WIDTH=32, N=5, SIZE=32). Outputs are sampled on the falling edge.
module tb_regfile_write_sched;
    import regfile_sched_pkg::*;

    localparam int REQS  = 4;
    localparam int WIDTH = 32;
    localparam int N     = 5;
    localparam int SIZE  = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [REQS-1:0]       req_valid;
    logic [REQS-1:0]       req_ready;
    logic [REQS*N-1:0]     req_index;
    logic [REQS*WIDTH-1:0] req_data;
    logic                  clear;
    logic                  busy;
    logic                  wr_en;
    logic [N-1:0]          wr_index;
    logic [WIDTH-1:0]      wr_data;
`ifdef REGFILE_SCHED_STATS_EN
    logic [REQS*STAT_W-1:0] grant_count;
`endif

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_write_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_index (req_index),
        .req_data  (req_data),
        .clear     (clear),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_data   (wr_data)
`ifdef REGFILE_SCHED_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge while the DUT is in CLEAR with cnt=0.
    // Checks clear writes 0..last on the following cycles.
    task automatic sweep(input int last);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            chk($sformatf("sweep_en[%0d]", k), 64'(wr_en), 64'd1);
            chk($sformatf("sweep_idx[%0d]", k), 64'(wr_index), 64'(k));
            chk($sformatf("sweep_data[%0d]", k), 64'(wr_data), 64'd0);
            chk($sformatf("sweep_busy[%0d]", k), 64'(busy), (k == SIZE - 1) ? 64'd0 : 64'd1);
        end
    endtask

    initial begin
        logic [REQS-1:0] one_hot;
        rst_n     = 1'b0;
        req_valid = '0;
        req_index = '0;
        req_data  = '0;
        clear     = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_index", 64'(wr_index), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
`ifdef REGFILE_SCHED_STATS_EN
        chk("rst_stats", 64'(grant_count), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Full post-reset sweep, then idle
        sweep(SIZE - 1);
        @(negedge clk);
        chk("idle_wr_en", 64'(wr_en), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

`ifdef REGFILE_SCHED_STATS_EN
        // Five accepted writes from requester 3. The counter must survive clear.
        req_valid = 4'b1000;
        req_index[3*N +: N] = 5'd20;
        repeat (5) @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("stat_req3", 64'(grant_count[63:48]), 64'd5);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("stat_after_clear", 64'(grant_count[63:48]), 64'd5);
        sweep(SIZE - 1);
        @(negedge clk);
`endif

        // Fairness: all valid, indices 4..7 -> grants 0,1,2,3,0
        for (int i = 0; i < REQS; i++) begin
            req_index[i*N +: N]         = N'(4 + i);
            req_data[i*WIDTH +: WIDTH]  = WIDTH'(32'h100 + i);
        end
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            one_hot = 4'b0001 << (g % 4);
            chk($sformatf("rr_ready[%0d]", g), 64'(req_ready), 64'(one_hot));
            @(negedge clk);
            chk($sformatf("rr_wr_en[%0d]", g), 64'(wr_en), 64'd1);
            chk($sformatf("rr_wr_idx[%0d]", g), 64'(wr_index), 64'(4 + (g % 4)));
            chk($sformatf("rr_wr_data[%0d]", g), 64'(wr_data), 64'(32'h100 + (g % 4)));
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_idle_wr_en", 64'(wr_en), 64'd0);
        chk("rr_idle_hold_idx", 64'(wr_index), 64'd4);

        // Lone requester 2
        req_valid = 4'b0100;
        req_index[2*N +: N]        = 5'd9;
        req_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
        #1;
        chk("r2_ready", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_valid = '0;
        chk("r2_wr_en", 64'(wr_en), 64'd1);
        chk("r2_wr_idx", 64'(wr_index), 64'd9);
        chk("r2_wr_data", 64'(wr_data), 64'hDEADBEEF);

        // Clear in RUN with requester 1 valid: nothing accepted, sweep restarts
        req_valid = 4'b0010;
        clear     = 1'b1;
        #1;
        chk("clr_run_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        clear     = 1'b0;
        req_valid = '0;
        chk("clr_run_busy", 64'(busy), 64'd1);
        chk("clr_run_wr_en", 64'(wr_en), 64'd0);
        sweep(12);

        // Clear mid-sweep at index 12: restart from 0 and run a full sweep
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_mid_busy", 64'(busy), 64'd1);
        chk("clr_mid_wr_en", 64'(wr_en), 64'd0);
        sweep(SIZE - 1);
        @(negedge clk);
        chk("clr_mid_done", 64'(wr_en), 64'd0);

        // Asynchronous reset mid-sweep
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd1);
        chk("arst_wr_en", 64'(wr_en), 64'd0);
        chk("arst_wr_idx", 64'(wr_index), 64'd0);
`ifdef REGFILE_SCHED_STATS_EN
        chk("arst_stats", 64'(grant_count[63:48]), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
